// File: rtl/bin2bcd_digits.sv
// bin2bcd_digits: sequential double-dabble converter from a WIDTH-bit unsigned
// value to eight registered BCD digits for an 8-digit display driver.
// One input bit is consumed per cycle. The digit outputs are loaded only when
// the FSM enters DONE, and they hold their value until the next load.
//
// Handshake: start is a request and is sampled only while busy=0 (state IDLE
// or DONE). A start seen in that cycle is accepted on the next rising edge.
// While busy=1, start is ignored and is neither queued nor remembered.
// done is a one-cycle pulse: it is high in the single cycle after the digits
// and ovf have been updated.
module bin2bcd_digits #(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       D0,
    output logic [3:0]       D1,
    output logic [3:0]       D2,
    output logic [3:0]       D3,
    output logic [3:0]       D4,
    output logic [3:0]       D5,
    output logic [3:0]       D6,
    output logic [3:0]       D7,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sr;
    logic [31:0]      r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf_int;
    logic [31:0]      r_digits;
    logic             r_ovf;

    logic [31:0]      w_acc_corr;
    logic [31:0]      w_acc_next;
    logic [63:0]      w_bin_ext;
    logic             w_bin_ovf;
    logic             w_last;

    // Widen before comparing so the test is exact at any WIDTH. Below 27 bits
    // the comparison is constant false.
    assign w_bin_ext = 64'(bin);
    assign w_bin_ovf = (w_bin_ext > 64'd99999999);

    // Last shift cycle: the counter was loaded with WIDTH and reaches 1 here.
    assign w_last = (r_state == S_SHIFT) && (r_cnt == CW'(1));

    // Add-3 correction on each nibble that is >= 5. The 4-bit wrap means there
    // is no carry into the next nibble.
    always_comb begin
        w_acc_corr = r_acc;
        for (int i = 0; i < 8; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_corr[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift the corrected accumulator left by one and bring in the MSB of sr.
    // The bit shifted out of the top nibble is discarded; that only happens
    // when the value is out of range, and then the digits are forced to F.
    assign w_acc_next = (w_acc_corr << 1) | {31'd0, r_sr[WIDTH-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. IDLE and DONE behave the same way, so a start held
    // high is accepted again in the DONE cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next_state = start ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: capture the input on accept, shift during SHIFT, and load the
    // output digits on the final shift edge, which is the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_digits  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sr      <= bin;
                        r_acc     <= '0;
                        r_cnt     <= CW'(WIDTH);
                        r_ovf_int <= w_bin_ovf;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_digits <= r_ovf_int ? 32'hFFFF_FFFF : w_acc_next;
                        r_ovf    <= r_ovf_int;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_SHIFT);
    assign done      = (r_state == S_DONE);
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

    assign D0 = r_digits[3:0];
    assign D1 = r_digits[7:4];
    assign D2 = r_digits[11:8];
    assign D3 = r_digits[15:12];
    assign D4 = r_digits[19:16];
    assign D5 = r_digits[23:20];
    assign D6 = r_digits[27:24];
    assign D7 = r_digits[31:28];

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Testbench for bin2bcd_digits at the default WIDTH=27. The reference model
// builds the digits with decimal division and remainder.
module tb_bin2bcd_digits;

    localparam int W = 27;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] bin;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [3:0]   D0, D1, D2, D3, D4, D5, D6, D7;
    logic [1:0]   dbg_state;
    logic [31:0]  w_digits;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [31:0] exp_q[$];

    bin2bcd_digits #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .D4(D4), .D5(D5), .D6(D6), .D7(D7),
        .dbg_state(dbg_state)
    );

    assign w_digits = {D7, D6, D5, D4, D3, D2, D1, D0};

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so that a hang still produces a report.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_bcd(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        if (v > 64'd99999999) return 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v);
        return (v > 64'd99999999);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full single conversion with latency, busy length, stability and result checks.
    task automatic run_convert(input logic [W-1:0] v, input string tag);
        int cycles;
        int busy_n;
        int chg;
        logic [31:0] d_prev;
        cycles = 0;
        busy_n = 0;
        chg    = 0;
        @(negedge clk);
        start  = 1'b1;
        bin    = v;
        d_prev = w_digits;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            cycles++;
            if (done) break;
            if (busy) busy_n++;
            if (w_digits !== d_prev) chg++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'd28);
        check({tag, "_busy_len"}, 64'(busy_n), 64'd27);
        check({tag, "_stable"}, 64'(chg), 64'd0);
        check({tag, "_digits"}, 64'(w_digits), 64'(ref_bcd(longint'(v))));
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(longint'(v))));
        d_prev = w_digits;
        @(negedge clk);
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(w_digits), 64'(d_prev));
    endtask

    initial begin
        int dones;
        int last_done;
        int cyc;
        int chg;
        int intervals_bad;
        logic need_toggle;
        logic [31:0] d_prev;
        logic [W-1:0] rv;

        // Reset.
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        check("reset_digits", 64'(w_digits), 64'd0);

        // Directed values.
        run_convert(W'(0), "zero");
        run_convert(W'(12345678), "d12345678");
        run_convert(W'(99999999), "all9");
        run_convert(W'(100000000), "ovf100M");
        run_convert(W'(7), "seven");

        // A start while busy is dropped.
        @(negedge clk);
        start = 1'b1;
        bin   = W'(555);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        bin   = W'(999);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (dones == 1) check("drop_digits", 64'(w_digits), 64'(ref_bcd(555)));
            end
        end
        check("drop_single_done", 64'(dones), 64'd1);
        check("drop_idle", 64'(busy), 64'd0);

        // Reset mid-conversion aborts with no done pulse.
        @(negedge clk);
        start = 1'b1;
        bin   = W'(4096);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_digits", 64'(w_digits), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        run_convert(W'(4096), "after_rst_4096");

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bin   = W'(5);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_wins_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("rst_wins_idle", 64'(busy), 64'd0);

        // Randomised values, including some above the displayable range.
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 3) rv = W'($urandom_range(134217727, 100000000));
            else            rv = W'($urandom_range(99999999, 0));
            run_convert(rv, "rand");
        end

        // Back-to-back with start held high and bin alternating between 10 and 20.
        dones         = 0;
        last_done     = -1;
        cyc           = 0;
        chg           = 0;
        intervals_bad = 0;
        need_toggle   = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start  = 1'b1;
        bin    = W'(10);
        d_prev = w_digits;
        exp_q.push_back(32'd10);
        need_toggle = 1'b1;
        for (int i = 0; i < 400 && dones < 5; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                dones++;
                if (exp_q.size() > 0) begin
                    check("b2b_digits", 64'(w_digits), 64'(ref_bcd(longint'(exp_q.pop_front()))));
                end else begin
                    check("b2b_queue_empty", 64'd1, 64'd0);
                end
                if (last_done >= 0 && (cyc - last_done) != 28) intervals_bad++;
                last_done = cyc;
            end else if (w_digits !== d_prev) begin
                chg++;
            end
            d_prev = w_digits;
            if (busy && need_toggle) begin
                bin = (bin == W'(10)) ? W'(20) : W'(10);
                need_toggle = 1'b0;
            end else if (!busy) begin
                exp_q.push_back(32'(bin));
                need_toggle = 1'b1;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(dones), 64'd5);
        check("b2b_period", 64'(intervals_bad), 64'd0);
        check("b2b_stable", 64'(chg), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
